// File: rtl/nibble_link_rx.sv
// Nibble link receiver: synchronises strobe/data/fin, packs nibble pairs into bytes, buffers them in a FIFO.
// Optional strobe-silence abort enabled by defining NIBBLE_LINK_RX_TIMEOUT_EN.
// state   | meaning
// IDLE    | not armed; strobe edges ignored
// WAIT_HI | armed, next strobe edge carries the high nibble
// WAIT_LO | high nibble held, next strobe edge completes a byte
// DONE    | transfer ended; terminal until reset, FIFO still readable
module nibble_link_rx #(
    parameter int DEPTH   = 4,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     strobe_in,
    input  logic [3:0]               data_in,
    input  logic                     fin_in,
    input  logic                     rd_en,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     partial,
    output logic                     overflow
`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
    ,
    output logic                     timeout
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC-1:0]   s_sh, f_sh;
    logic [SYNC*4-1:0] d_sh;
    logic              s_prev;
    logic              s_sync, f_sync, s_edge;
    logic [3:0]        d_sync;
    logic [3:0]        hi;
    logic              push_req, hi_load, set_partial, set_timeout, tmo_hit;
    logic [7:0]        mem [DEPTH];
    logic [AW:0]       wp, rp;
    logic              pop, push_ok;

    assign s_sync = s_sh[SYNC-1];
    assign f_sync = f_sh[SYNC-1];
    assign d_sync = d_sh[SYNC*4-1 -: 4];
    assign s_edge = s_sync & ~s_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_sh   <= '0;
            f_sh   <= '0;
            d_sh   <= '0;
            s_prev <= 1'b0;
        end else begin
            s_sh   <= {s_sh[SYNC-2:0], strobe_in};
            f_sh   <= {f_sh[SYNC-2:0], fin_in};
            d_sh   <= {d_sh[SYNC*4-5:0], data_in};
            s_prev <= s_sync;
        end
    end

`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    logic          in_wait;

    assign in_wait = (state == WAIT_HI) || (state == WAIT_LO);
    assign tmo_hit = in_wait && (tmr == '0);

    // Down-counter reloaded on every strobe edge and whenever not waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr     <= TW'(TIMEOUT - 1);
            timeout <= 1'b0;
        end else begin
            if (!in_wait || s_edge)
                tmr <= TW'(TIMEOUT - 1);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;
            if (set_timeout)
                timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // fin is sticky, so its level doubles as the edge and covers fin already high at arm time.
    always_comb begin
        state_nxt   = state;
        push_req    = 1'b0;
        hi_load     = 1'b0;
        set_partial = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                hi_load = s_edge;
                if (f_sync) begin
                    state_nxt   = DONE;
                    set_partial = s_edge;
                end else if (s_edge) begin
                    state_nxt = WAIT_LO;
                end else if (tmo_hit) begin
                    state_nxt   = DONE;
                    set_timeout = 1'b1;
                end
            end
            WAIT_LO: begin
                push_req = s_edge;
                if (f_sync) begin
                    state_nxt   = DONE;
                    set_partial = ~s_edge;
                end else if (s_edge) begin
                    state_nxt = WAIT_HI;
                end else if (tmo_hit) begin
                    state_nxt   = DONE;
                    set_partial = 1'b1;
                    set_timeout = 1'b1;
                end
            end
            default: state_nxt = DONE;
        endcase
    end

    assign done    = (state == DONE);
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign pop     = rd_en && !empty;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi         <= 4'h0;
            partial    <= 1'b0;
            overflow   <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= pop;
            if (hi_load)
                hi <= d_sync;
            if (set_partial)
                partial <= 1'b1;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop) begin
                rp       <= rp + 1'b1;
                byte_out <= mem[rp[AW-1:0]];
            end
        end
    end

    // When full with a simultaneous pop, wp and rp share a slot: the pop reads the old byte first.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp[AW-1:0]] <= {hi, d_sync};
    end

endmodule

// File: tb/tb_nibble_link_rx.sv
// Scoreboard bench for nibble_link_rx: stimulus queues expected bytes, a monitor checks each byte_valid pulse.
module tb_nibble_link_rx;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       strobe_in;
    logic [3:0] data_in;
    logic       fin_in;
    logic       rd_en;
    logic [7:0] byte_out;
    logic       byte_valid, empty, full, done, partial, overflow;
    logic [$clog2(DEPTH):0] count;
`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    nibble_link_rx #(
        .DEPTH(DEPTH), .SYNC(SYNC)
`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .strobe_in(strobe_in),
        .data_in(data_in), .fin_in(fin_in), .rd_en(rd_en),
        .byte_out(byte_out), .byte_valid(byte_valid), .empty(empty),
        .full(full), .count(count), .done(done), .partial(partial),
        .overflow(overflow)
`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && byte_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte", byte_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (byte_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", byte_out, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; strobe_in = 1'b0; fin_in = 1'b0;
        data_in = 4'h0; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_nibble(input logic [3:0] n);
        @(negedge clk);
        data_in = n;
        repeat (2) @(negedge clk);
        strobe_in = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        strobe_in = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // Raises strobe and holds rd_en exactly over the cycle in which the byte is pushed.
    task automatic send_nibble_with_pop(input logic [3:0] n);
        @(negedge clk);
        data_in = n;
        repeat (2) @(negedge clk);
        strobe_in = 1'b1;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        strobe_in = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_fin();
        @(negedge clk);
        fin_in = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] stream_bytes [7];
        stream_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};

        // Reset values
        do_reset();
        check("rst_byte_out", byte_out, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_partial", partial, 0);
        check("rst_overflow", overflow, 0);

        // Pop while empty must not produce a byte (monitor flags any pulse)
        pop_one();
        check("empty_pop_count", count, 0);

        // Stream 1..14, popping after each byte so DEPTH=4 never overflows
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_nibble(4'(2 * i + 1));
            send_nibble(4'(2 * i + 2));
            exp_q.push_back(stream_bytes[i]);
            pop_one();
        end
        send_fin();
        check("stream_done", done, 1);
        check("stream_partial", partial, 0);
        check("stream_overflow", overflow, 0);
        check("stream_empty", empty, 1);
        check("stream_drained", exp_q.size(), 0);

        // Odd nibble count: A,B,C then fin
        do_reset();
        start = 1'b1;
        send_nibble(4'hA);
        send_nibble(4'hB);
        send_nibble(4'hC);
        send_fin();
        check("odd_count", count, 1);
        check("odd_partial", partial, 1);
        check("odd_done", done, 1);
        exp_q.push_back(8'hAB);
        pop_one();
        check("odd_drained", exp_q.size(), 0);

        // Overflow: 0,1,0,2,...,0,5 with no pops
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send_nibble(4'h0);
            send_nibble(4'(i));
        end
        check("ovf_full", full, 1);
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) pop_one();
        check("ovf_empty", empty, 1);
        check("ovf_drained", exp_q.size(), 0);

        // Full with a pop on the push cycle
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_nibble(4'(i));
            send_nibble(4'(i));
            exp_q.push_back({4'(i), 4'(i)});
        end
        check("fp_full_before", full, 1);
        exp_q.push_back(8'h55);
        send_nibble(4'h5);
        send_nibble_with_pop(4'h5);
        check("fp_count", count, 4);
        check("fp_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) pop_one();
        check("fp_drained", exp_q.size(), 0);

        // Reset mid-stream with 2 bytes buffered and a high nibble pending
        do_reset();
        start = 1'b1;
        send_nibble(4'h1); send_nibble(4'h2);
        send_nibble(4'h3); send_nibble(4'h4);
        send_nibble(4'h5);
        check("mid_count_pre", count, 2);
        #2 reset = 1'b1;
        #1;
        check("mid_byte_out", byte_out, 0);
        check("mid_empty", empty, 1);
        check("mid_count", count, 0);
        check("mid_full", full, 0);
        check("mid_done", done, 0);
        check("mid_partial", partial, 0);
        check("mid_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_nibble(4'hC);
        send_nibble(4'hD);
        send_fin();
        check("fresh_count", count, 1);
        check("fresh_partial", partial, 0);
        exp_q.push_back(8'hCD);
        pop_one();
        check("fresh_drained", exp_q.size(), 0);

        // fin already high at arm time
        do_reset();
        fin_in = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        check("fin_pre_idle", done, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("fin_pre_done", done, 1);
        check("fin_pre_count", count, 0);

`ifdef NIBBLE_LINK_RX_TIMEOUT_EN
        do_reset();
        start = 1'b1;
        send_nibble(4'h7);
        repeat (24) @(negedge clk);
        check("tmo_done", done, 1);
        check("tmo_flag", timeout, 1);
        check("tmo_partial", partial, 1);
`endif

        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
